// File: rtl/blit_cmd_issuer_pkg.sv
// Shared definitions for the blitter command issuer: register offsets,
// STATUS bit positions, issue FSM state type and the command word type.
package blit_pkg;

    // Register word offsets within the hwregs block
    localparam logic [2:0] BLIT_REG_W0       = 3'd0;
    localparam logic [2:0] BLIT_REG_W1       = 3'd1;
    localparam logic [2:0] BLIT_REG_W2       = 3'd2;
    localparam logic [2:0] BLIT_REG_W3       = 3'd3;
    localparam logic [2:0] BLIT_REG_STATUS   = 3'd4;
    localparam logic [2:0] BLIT_REG_CMDCOUNT = 3'd5;

    // STATUS register bit positions
    localparam int STAT_CREDITS_LSB = 0;
    localparam int STAT_PENDING_BIT = 8;
    localparam int STAT_REJECT_BIT  = 9;
    localparam int STAT_OVF_BIT     = 10;

    // Overflow flag position inside the blitter status word
    localparam int BLIT_STATUS_OVF_BIT = 1;

    typedef enum logic {
        BI_IDLE    = 1'b0,
        BI_PENDING = 1'b1
    } blit_issue_state_t;

    typedef logic [127:0] blit_cmd_t;

endpackage

// File: rtl/blit_cmd_issuer_if.sv
// Bundle of the CPU register bus, the command push port and the blitter
// feedback signals. The issuer uses the slave modport; the CPU/blitter side
// (or a bench) uses master. dbg_state exposes the issue FSM state.
interface blit_cmd_issuer_if;
    import blit_pkg::*;

    logic              hwregs_write;
    logic              hwregs_read;
    logic [2:0]        hwregs_addr;
    logic [31:0]       hwregs_wdata;
    logic [31:0]       hwregs_rdata;
    logic              hwregs_rdvalid;
    blit_cmd_t         blit_cmd;
    logic              blit_cmd_valid;
    logic [7:0]        blit_fifo_slots_free;
    logic [31:0]       blit_status;
    blit_issue_state_t dbg_state;

    modport slave (
        input  hwregs_write, hwregs_read, hwregs_addr, hwregs_wdata,
        input  blit_fifo_slots_free, blit_status,
        output hwregs_rdata, hwregs_rdvalid, blit_cmd, blit_cmd_valid, dbg_state
    );

    modport master (
        output hwregs_write, hwregs_read, hwregs_addr, hwregs_wdata,
        output blit_fifo_slots_free, blit_status,
        input  hwregs_rdata, hwregs_rdvalid, blit_cmd, blit_cmd_valid, dbg_state
    );

endinterface

// File: rtl/blit_cmd_issuer_credit_tracker.sv
// Credit tracker: the FIFO's free-slot count lags our pushes, so pushes that
// the count cannot yet reflect are subtracted. The window covers the push
// presented this cycle plus the previous FIFO_STATUS_LAT cycles, which keeps
// the estimate conservative. Result saturates at 0 and is capped at FIFO_DEPTH.
module blit_credit_tracker #(
    parameter int FIFO_DEPTH      = 16,
    parameter int FIFO_STATUS_LAT = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] slots_free,
    output logic [7:0] credits
);
    localparam logic [7:0] DEPTH_8 = 8'(FIFO_DEPTH);

    logic [FIFO_STATUS_LAT-1:0] hist_q;
    logic [FIFO_STATUS_LAT-1:0] hist_d;
    logic [7:0]                 inflight;
    logic [7:0]                 avail;

    // Shift the push history by one cycle
    always_comb begin
        hist_d[0] = push;
        for (int i = 1; i < FIFO_STATUS_LAT; i++) begin
            hist_d[i] = hist_q[i-1];
        end
    end

    // Push history register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    // Count unreflected pushes and derive saturating, capped credits
    always_comb begin
        inflight = {7'd0, push};
        for (int i = 0; i < FIFO_STATUS_LAT; i++) begin
            inflight = inflight + {7'd0, hist_q[i]};
        end
        avail   = (slots_free > inflight) ? (slots_free - inflight) : 8'd0;
        credits = (avail > DEPTH_8) ? DEPTH_8 : avail;
    end

endmodule

// File: rtl/blit_cmd_issuer.sv
// Blitter command issuer: gathers W0..W3 register writes into a 128-bit
// command, pushes it to the blitter command FIFO when credits allow, and
// holds at most one command in a pending buffer when they do not.
// Optional feature: define BLIT_CMD_COUNT_EN to add the 32-bit push counter
// at offset 5; without it offset 5 reads 0.
module blit_cmd_issuer
    import blit_pkg::*;
#(
    parameter int FIFO_DEPTH      = 16,
    parameter int FIFO_STATUS_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    blit_cmd_issuer_if.slave  bus
);
    logic [3:0][31:0]  stage_q, stage_d;
    blit_cmd_t         cmd_q, cmd_d;
    blit_cmd_t         pend_q, pend_d;
    logic              valid_q, valid_d;
    blit_issue_state_t state_q, state_d;
    logic              reject_q, reject_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rdvalid_q, rdvalid_d;
    logic [7:0]        credits;
    logic              wr_w3;
    logic              wr_status;
    logic              reject_set;
    blit_cmd_t         new_cmd;
    logic              unused_bits;
`ifdef BLIT_CMD_COUNT_EN
    logic [31:0]       count_q, count_d;
`endif

    assign wr_w3     = bus.hwregs_write && (bus.hwregs_addr == BLIT_REG_W3);
    assign wr_status = bus.hwregs_write && (bus.hwregs_addr == BLIT_REG_STATUS);
    // The W3 word being written completes the command in the same cycle
    assign new_cmd   = {bus.hwregs_wdata, stage_q[2], stage_q[1], stage_q[0]};
    assign unused_bits = ^{bus.blit_status[31:2], bus.blit_status[0]};

    blit_credit_tracker #(
        .FIFO_DEPTH      (FIFO_DEPTH),
        .FIFO_STATUS_LAT (FIFO_STATUS_LAT)
    ) u_credit (
        .clock      (clock),
        .reset      (reset),
        .push       (valid_q),
        .slots_free (bus.blit_fifo_slots_free),
        .credits    (credits)
    );

    // Next-state logic: staging, issue FSM, reject flag, counter, read mux
    always_comb begin
        stage_d    = stage_q;
        cmd_d      = cmd_q;
        pend_d     = pend_q;
        state_d    = state_q;
        valid_d    = 1'b0;
        rdvalid_d  = 1'b0;
        rdata_d    = '0;
        reject_set = 1'b0;

        if (bus.hwregs_write && !bus.hwregs_addr[2]) begin
            stage_d[bus.hwregs_addr[1:0]] = bus.hwregs_wdata;
        end

        case (state_q)
            BI_IDLE: begin
                if (wr_w3) begin
                    if (credits != 8'd0) begin
                        cmd_d   = new_cmd;
                        valid_d = 1'b1;
                    end else begin
                        pend_d  = new_cmd;
                        state_d = BI_PENDING;
                    end
                end
            end
            BI_PENDING: begin
                if (credits != 8'd0) begin
                    cmd_d   = pend_q;
                    valid_d = 1'b1;
                    state_d = BI_IDLE;
                end
                // Only one command can wait; a further W3 is dropped
                if (wr_w3) begin
                    reject_set = 1'b1;
                end
            end
            default: state_d = BI_IDLE;
        endcase

        // A new reject wins over a simultaneous write-1-clear
        if (reject_set) begin
            reject_d = 1'b1;
        end else if (wr_status && bus.hwregs_wdata[STAT_REJECT_BIT]) begin
            reject_d = 1'b0;
        end else begin
            reject_d = reject_q;
        end

`ifdef BLIT_CMD_COUNT_EN
        count_d = (bus.hwregs_write && (bus.hwregs_addr == BLIT_REG_CMDCOUNT)) ? 32'd0 : count_q;
        if (valid_q) begin
            count_d = count_d + 32'd1;
        end
`endif

        if (bus.hwregs_read) begin
            rdvalid_d = 1'b1;
            case (bus.hwregs_addr)
                BLIT_REG_W0, BLIT_REG_W1, BLIT_REG_W2, BLIT_REG_W3:
                    rdata_d = stage_q[bus.hwregs_addr[1:0]];
                BLIT_REG_STATUS: begin
                    rdata_d[STAT_CREDITS_LSB +: 8] = credits;
                    rdata_d[STAT_PENDING_BIT]      = (state_q == BI_PENDING);
                    rdata_d[STAT_REJECT_BIT]       = reject_q;
                    rdata_d[STAT_OVF_BIT]          = bus.blit_status[BLIT_STATUS_OVF_BIT];
                end
`ifdef BLIT_CMD_COUNT_EN
                BLIT_REG_CMDCOUNT: rdata_d = count_q;
`endif
                default: rdata_d = '0;
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stage_q   <= '0;
            cmd_q     <= '0;
            pend_q    <= '0;
            valid_q   <= 1'b0;
            state_q   <= BI_IDLE;
            reject_q  <= 1'b0;
            rdata_q   <= '0;
            rdvalid_q <= 1'b0;
`ifdef BLIT_CMD_COUNT_EN
            count_q   <= '0;
`endif
        end else begin
            stage_q   <= stage_d;
            cmd_q     <= cmd_d;
            pend_q    <= pend_d;
            valid_q   <= valid_d;
            state_q   <= state_d;
            reject_q  <= reject_d;
            rdata_q   <= rdata_d;
            rdvalid_q <= rdvalid_d;
`ifdef BLIT_CMD_COUNT_EN
            count_q   <= count_d;
`endif
        end
    end

    assign bus.blit_cmd       = cmd_q;
    assign bus.blit_cmd_valid = valid_q;
    assign bus.hwregs_rdata   = rdata_q;
    assign bus.hwregs_rdvalid = rdvalid_q;
    assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_blit_cmd_issuer.sv
// Bench for blit_cmd_issuer. The reference model tracks staging words, the
// pending slot, the reject flag and the list of push cycles; credits are
// recomputed from that list. Expected pushes and read data go into queues
// that a negedge monitor pops whenever the DUT presents a push or read data.
module tb_blit_cmd_issuer;
    import blit_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    blit_cmd_issuer_if bus();

    blit_cmd_issuer #(
        .FIFO_DEPTH      (DEPTH),
        .FIFO_STATUS_LAT (LAT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and cycle counter
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard queues
    logic [127:0] exp_q[$];
    int           exp_cyc_q[$];
    logic [31:0]  exp_rd_q[$];
    int           exp_rd_cyc_q[$];
    logic [127:0] last_cmd = '0;

    // Reference model state
    logic [31:0]  m_stage[4];
    bit           m_pend;
    logic [127:0] m_pbuf;
    bit           m_rej;
    logic [31:0]  m_cnt;
    int           push_cyc[$];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic int model_credits(input int n);
        int inflight = 0;
        int c;
        foreach (push_cyc[i]) begin
            if (push_cyc[i] <= n && n - push_cyc[i] <= LAT) inflight++;
        end
        c = int'(bus.blit_fifo_slots_free) - inflight;
        if (c < 0) c = 0;
        if (c > DEPTH) c = DEPTH;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_stage[i] = '0;
        m_pend = 0; m_pbuf = '0; m_rej = 0; m_cnt = '0;
        push_cyc.delete();
        exp_q.delete(); exp_cyc_q.delete();
        exp_rd_q.delete(); exp_rd_cyc_q.delete();
        last_cmd = '0;
    endtask

    task automatic model_issue(input logic [127:0] c, input int at);
        exp_q.push_back(c);
        exp_cyc_q.push_back(at);
        push_cyc.push_back(at);
    endtask

    // Apply the register-map rules for one clock cycle n (the cycle whose
    // closing edge comes next); reads see the state before that edge.
    task automatic model_eval(input bit wr, input bit rd, input logic [2:0] a, input logic [31:0] d);
        int n = cyc;
        int cr = model_credits(n);
        bit push_now = (push_cyc.size() > 0) && (push_cyc[push_cyc.size()-1] == n);
        bit rej_set = 0;
        logic [31:0] rv;
        logic [7:0] cr8 = 8'(cr);
        if (rd) begin
            case (a)
                3'd0, 3'd1, 3'd2, 3'd3: rv = m_stage[a];
                3'd4: rv = {21'd0, bus.blit_status[1], m_rej, m_pend, cr8};
`ifdef BLIT_CMD_COUNT_EN
                3'd5: rv = m_cnt;
`endif
                default: rv = '0;
            endcase
            exp_rd_q.push_back(rv);
            exp_rd_cyc_q.push_back(n + 1);
        end
`ifdef BLIT_CMD_COUNT_EN
        if (wr && a == 3'd5) m_cnt = '0;
        if (push_now) m_cnt = m_cnt + 32'd1;
`endif
        if (!m_pend) begin
            if (wr && a == 3'd3) begin
                if (cr > 0) model_issue({d, m_stage[2], m_stage[1], m_stage[0]}, n + 1);
                else begin
                    m_pend = 1;
                    m_pbuf = {d, m_stage[2], m_stage[1], m_stage[0]};
                end
            end
        end else begin
            rej_set = wr && (a == 3'd3);
            if (cr > 0) begin
                model_issue(m_pbuf, n + 1);
                m_pend = 0;
            end
        end
        if (rej_set) m_rej = 1;
        else if (wr && a == 3'd4 && d[9]) m_rej = 0;
        if (wr && a < 3'd4) m_stage[a] = d;
    endtask

    // Driver: one bus cycle, inputs changed just after the active edge
    task automatic step(input bit wr, input bit rd, input logic [2:0] a, input logic [31:0] d);
        bus.hwregs_write = wr;
        bus.hwregs_read  = rd;
        bus.hwregs_addr  = a;
        bus.hwregs_wdata = d;
        model_eval(wr, rd, a, d);
        @(posedge clock);
        #1;
        bus.hwregs_write = 1'b0;
        bus.hwregs_read  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 3'd0, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_cmd", bus.blit_cmd, 128'd0);
        check("rst_valid", bus.blit_cmd_valid, 1'b0);
        check("rst_rdata", bus.hwregs_rdata, 32'd0);
        check("rst_rdvalid", bus.hwregs_rdvalid, 1'b0);
        check("rst_state", bus.dbg_state, BI_IDLE);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: pops expectations whenever the DUT presents a push or read data
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
                    check("missing_push", 128'd0, exp_q[0]);
                    last_cmd = exp_q.pop_front();
                    void'(exp_cyc_q.pop_front());
                end
                if (bus.blit_cmd_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_push", bus.blit_cmd_valid, 1'b0);
                    end else begin
                        check("push_cmd", bus.blit_cmd, exp_q[0]);
                        check("push_cycle", 128'(cyc), 128'(exp_cyc_q[0]));
                        last_cmd = exp_q.pop_front();
                        void'(exp_cyc_q.pop_front());
                    end
                end else begin
                    check("cmd_hold", bus.blit_cmd, last_cmd);
                end
                while (exp_rd_cyc_q.size() > 0 && exp_rd_cyc_q[0] < cyc) begin
                    check("missing_rdvalid", 128'd0, 128'(exp_rd_q[0]));
                    void'(exp_rd_q.pop_front());
                    void'(exp_rd_cyc_q.pop_front());
                end
                if (bus.hwregs_rdvalid) begin
                    if (exp_rd_q.size() == 0) begin
                        check("unexpected_rdvalid", bus.hwregs_rdvalid, 1'b0);
                    end else begin
                        check("rdata", bus.hwregs_rdata, exp_rd_q[0]);
                        check("rd_cycle", 128'(cyc), 128'(exp_rd_cyc_q[0]));
                        void'(exp_rd_q.pop_front());
                        void'(exp_rd_cyc_q.pop_front());
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        bit          wr, rd;
        logic [2:0]  a;
        logic [31:0] d;

        bus.hwregs_write = 1'b0;
        bus.hwregs_read  = 1'b0;
        bus.hwregs_addr  = '0;
        bus.hwregs_wdata = '0;
        bus.blit_fifo_slots_free = 8'd16;
        bus.blit_status = '0;
        #2;
        do_reset();

        // Basic issue with credits available
        step(1, 0, 3'd0, 32'd1);
        step(1, 0, 3'd1, 32'd2);
        step(1, 0, 3'd2, 32'd3);
        step(1, 0, 3'd3, 32'd4);
        idle(2);
        for (int i = 0; i < 4; i++) step(0, 1, 3'(i), 32'd0);

        // Back-to-back W3 writes, then credits read while three are unreflected
        idle(4);
        for (int i = 0; i < 3; i++) step(1, 0, 3'd3, $urandom);
        step(0, 1, 3'd4, 32'd0);
        idle(3);
        step(0, 1, 3'd4, 32'd0);

        // No credits: pend, reject, then release with one slot
        bus.blit_fifo_slots_free = 8'd0;
        step(1, 0, 3'd3, 32'h0000_00AA);
        step(0, 1, 3'd4, 32'd0);
        step(1, 0, 3'd3, 32'h0000_00BB);
        step(0, 1, 3'd4, 32'd0);
        step(0, 1, 3'd3, 32'd0);
        bus.blit_fifo_slots_free = 8'd1;
        idle(4);
        step(0, 1, 3'd4, 32'd0);

        // Reject write-1-clear, overflow bit passthrough
        bus.blit_status = 32'h2;
        step(1, 0, 3'd4, 32'h0000_0200);
        step(0, 1, 3'd4, 32'd0);
        bus.blit_status = 32'h0;

        // Reset while a command is pending: it must never be pushed
        bus.blit_fifo_slots_free = 8'd0;
        step(1, 0, 3'd3, 32'h1234_5678);
        step(0, 1, 3'd4, 32'd0);
        do_reset();
        bus.blit_fifo_slots_free = 8'd16;
        idle(5);
        step(0, 1, 3'd4, 32'd0);
        step(0, 1, 3'd3, 32'd0);

        // Command counter (reads 0 when the feature is absent)
        step(0, 1, 3'd5, 32'd0);
        for (int i = 0; i < 5; i++) step(1, 0, 3'd3, $urandom);
        idle(4);
        step(0, 1, 3'd5, 32'd0);
        step(1, 0, 3'd5, 32'hDEAD_BEEF);
        step(0, 1, 3'd5, 32'd0);
        step(0, 1, 3'd6, 32'd0);
        step(0, 1, 3'd7, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) bus.blit_fifo_slots_free = 8'($urandom_range(0, 20));
            bus.blit_status = $urandom;
            wr = ($urandom_range(0, 1) == 0);
            rd = ($urandom_range(0, 2) == 0);
            a  = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'($urandom_range(0, 7));
            d  = $urandom;
            step(wr, rd, a, d);
        end

        // Drain
        bus.blit_fifo_slots_free = 8'd16;
        idle(10);
        check("exp_push_drained", 128'(exp_q.size()), 128'd0);
        check("exp_read_drained", 128'(exp_rd_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
